layer_fetch_arbiter: RTL and testbench

//  Round-robin arbiter sharing one external pixel-memory read port among the layer draw units.

---
 rtl/layer_fetch_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_layer_fetch_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_fetch_arbiter.sv
// Round-robin arbiter that shares one pixel-memory read port among the layer draw units.
// Each grant is one fixed-length read burst; returned words are steered to the grantee only.
module layer_fetch_arbiter #(
    parameter int pNumReq    = 4,
    parameter int pAddrWidth = 19,
    parameter int pDataWidth = 16,
    parameter int pBurstLen  = 8
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iFe,
    input  logic [pNumReq-1:0]            iReq,
    input  logic [pNumReq*pAddrWidth-1:0] iReqAddr,
    output logic [pNumReq-1:0]            oGnt,
    output logic [pAddrWidth-1:0]         oMemAddr,
    output logic                          oMemRe,
    input  logic                          iMemRdy,
    input  logic [pDataWidth-1:0]         iMemRd,
    input  logic                          iMemRvd,
    output logic [pDataWidth-1:0]         oRd,
    output logic [pNumReq-1:0]            oRvd,
    output logic                          oBusy,
    output logic [1:0]                    oState
);

    localparam int PtrW = $clog2(pNumReq);
    localparam int CntW = $clog2(pBurstLen) + 1;
    localparam logic [CntW-1:0] BurstLast = CntW'(pBurstLen - 1);
    localparam logic [CntW-1:0] BurstFull = CntW'(pBurstLen);
    localparam logic [PtrW:0]   NumReqW   = (PtrW + 1)'(pNumReq);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshake: a command is transferred on every rising edge where oMemRe and iMemRdy
    // are both high; oMemAddr is stable while oMemRe waits for iMemRdy. Returned words
    // carry no backpressure: iMemRvd qualifies iMemRd for exactly one cycle, in order.

    state_t                state;
    state_t                state_nxt;
    logic [PtrW-1:0]       ptr;
    logic [PtrW-1:0]       owner;
    logic [PtrW-1:0]       pick_idx;
    logic [PtrW-1:0]       cand;
    logic [PtrW-1:0]       ptr_after;
    logic [PtrW:0]         sum;
    logic [PtrW:0]         owner_inc;
    logic                  pick_valid;
    logic [pAddrWidth-1:0] base;
    logic [pAddrWidth-1:0] pick_addr;
    logic [CntW-1:0]       issue_cnt;
    logic [CntW-1:0]       rtn_cnt;
    logic                  fe_pend;
    logic                  accept;
    logic                  issue_done;
    logic                  drain_done;

    // Walk from the highest offset down so the smallest offset from ptr wins last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int i = pNumReq - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PtrW + 1)'(i);
            if (sum >= NumReqW) begin
                sum = sum - NumReqW;
            end
            cand = sum[PtrW-1:0];
            if (iReq[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        for (int k = 0; k < pNumReq; k++) begin
            if (pick_idx == PtrW'(k)) begin
                pick_addr = iReqAddr[k*pAddrWidth +: pAddrWidth];
            end
        end
    end

    // A frame end seen at any point of the burst restarts the rotation at requester 0.
    always_comb begin
        owner_inc = {1'b0, owner} + (PtrW + 1)'(1);
        if (owner_inc >= NumReqW) begin
            owner_inc = '0;
        end
        ptr_after = (fe_pend || iFe) ? '0 : owner_inc[PtrW-1:0];
    end

    assign accept     = (state == ISSUE) && iMemRdy;
    assign issue_done = accept && (issue_cnt == BurstLast);
    assign drain_done = (rtn_cnt == BurstFull);

    assign oMemRe   = (state == ISSUE);
    assign oMemAddr = oMemRe ? (base + pAddrWidth'(issue_cnt)) : '0;
    assign oBusy    = (state != IDLE);
    assign oState   = state;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   if (issue_done) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oGnt      <= '0;
            oRd       <= '0;
            oRvd      <= '0;
            ptr       <= '0;
            owner     <= '0;
            base      <= '0;
            issue_cnt <= '0;
            rtn_cnt   <= '0;
            fe_pend   <= 1'b0;
        end else begin
            oRd  <= iMemRd;
            oRvd <= oGnt & {pNumReq{iMemRvd}};
            unique case (state)
                IDLE: begin
                    fe_pend <= 1'b0;
                    if (iFe) begin
                        ptr <= '0;
                    end
                    if (pick_valid) begin
                        oGnt      <= {{(pNumReq-1){1'b0}}, 1'b1} << pick_idx;
                        owner     <= pick_idx;
                        base      <= pick_addr;
                        issue_cnt <= '0;
                        rtn_cnt   <= '0;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        issue_cnt <= issue_cnt + CntW'(1);
                    end
                    if (iMemRvd) begin
                        rtn_cnt <= rtn_cnt + CntW'(1);
                    end
                    if (iFe) begin
                        fe_pend <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        oGnt    <= '0;
                        ptr     <= ptr_after;
                        fe_pend <= 1'b0;
                    end else begin
                        if (iMemRvd) begin
                            rtn_cnt <= rtn_cnt + CntW'(1);
                        end
                        if (iFe) begin
                            fe_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    oGnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_fetch_arbiter.sv
// Bench for layer_fetch_arbiter: a burst-level reference model plus a memory model,
// with directed scenarios followed by randomized request/ready/frame-end traffic.
module tb_layer_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int B  = 8;

    logic            iClk = 1'b0;
    logic            iRst = 1'b0;
    logic            iFe = 1'b0;
    logic [N-1:0]    iReq = '0;
    logic [N*AW-1:0] iReqAddr = '0;
    logic [N-1:0]    oGnt;
    logic [AW-1:0]   oMemAddr;
    logic            oMemRe;
    logic            iMemRdy = 1'b0;
    logic [DW-1:0]   iMemRd = '0;
    logic            iMemRvd = 1'b0;
    logic [DW-1:0]   oRd;
    logic [N-1:0]    oRvd;
    logic            oBusy;
    logic [1:0]      oState;

    layer_fetch_arbiter #(
        .pNumReq(N), .pAddrWidth(AW), .pDataWidth(DW), .pBurstLen(B)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iFe(iFe), .iReq(iReq), .iReqAddr(iReqAddr),
        .oGnt(oGnt), .oMemAddr(oMemAddr), .oMemRe(oMemRe), .iMemRdy(iMemRdy),
        .iMemRd(iMemRd), .iMemRvd(iMemRvd), .oRd(oRd), .oRvd(oRvd),
        .oBusy(oBusy), .oState(oState)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: one burst owner at a time, counted in words issued and returned.
    int            m_owner;
    int            m_issued;
    int            m_ret;
    int            m_ptr;
    bit            m_fe;
    logic [AW-1:0] m_base;
    logic [N-1:0]  m_rvd;
    logic [DW-1:0] m_rd;

    // Memory model and scoreboard.
    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    int            last_due = 0;
    int            rdy_mode = 0;
    int            dly_fixed = 3;
    int            stale_n = 0;
    logic [DW-1:0] exp_q[$];

    int            gnt_log[$];
    logic [AW-1:0] addr_log[$];
    int            rvd_cnt[N];
    logic [N-1:0]  prev_gnt = '0;
    logic [AW-1:0] t4_exp[8];

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[18:16], 13'h0} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_issued = 0; m_ret = 0; m_ptr = 0; m_fe = 0;
        m_base = '0; m_rvd = '0; m_rd = '0;
    endtask

    task automatic flush_mem();
        mq_addr.delete(); mq_due.delete(); exp_q.delete(); last_due = cyc;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); addr_log.delete();
        for (int k = 0; k < N; k++) rvd_cnt[k] = 0;
    endtask

    // Drives the memory side for the coming edge, using the model's view of what is issued.
    task automatic mem_drive();
        int d;
        cyc++;
        case (rdy_mode)
            0:       iMemRdy = 1'b1;
            1:       iMemRdy = ~iMemRdy;
            default: iMemRdy = ($urandom_range(0, 3) != 0);
        endcase
        if (iRst && oMemRe && iMemRdy) addr_log.push_back(oMemAddr);
        if (iRst && m_owner >= 0 && m_issued < B && iMemRdy) begin
            logic [AW-1:0] a;
            a = AW'(m_base + AW'(m_issued));
            d = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 5));
            d = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
            last_due = d;
            mq_addr.push_back(a);
            mq_due.push_back(d);
            exp_q.push_back(dat(a));
        end
        if (stale_n > 0) begin
            stale_n--;
            iMemRvd = 1'b1;
            iMemRd  = DW'($urandom);
        end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            void'(mq_due.pop_front());
            iMemRvd = 1'b1;
            iMemRd  = dat(mq_addr.pop_front());
        end else begin
            iMemRvd = 1'b0;
            iMemRd  = DW'($urandom);
        end
    endtask

    // Predicts the state after the coming edge from the inputs now on the pins.
    task automatic model_step();
        int pre;
        int win;
        if (!iRst) begin
            model_reset();
            return;
        end
        pre   = m_owner;
        m_rvd = (pre >= 0 && iMemRvd) ? (N'(1) << pre) : '0;
        m_rd  = iMemRd;
        if (m_owner < 0) begin
            win = -1;
            for (int i = 0; i < N; i++) begin
                if (win < 0 && iReq[(m_ptr + i) % N]) win = (m_ptr + i) % N;
            end
            if (win >= 0) begin
                m_owner  = win;
                m_base   = iReqAddr[win*AW +: AW];
                m_issued = 0;
                m_ret    = 0;
            end
            m_fe = 0;
            if (iFe) m_ptr = 0;
        end else if (m_issued == B) begin
            if (m_ret == B) begin
                m_ptr   = (m_fe || iFe) ? 0 : (m_owner + 1) % N;
                m_owner = -1;
                m_fe    = 0;
            end else begin
                if (iMemRvd) m_ret++;
                if (iFe) m_fe = 1;
            end
        end else begin
            if (iMemRdy) m_issued++;
            if (iMemRvd) m_ret++;
            if (iFe) m_fe = 1;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]  e_gnt;
        logic          e_re;
        logic [AW-1:0] e_addr;
        e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_re   = (m_owner >= 0) && (m_issued < B);
        e_addr = e_re ? AW'(m_base + AW'(m_issued)) : '0;
        chk("gnt", oGnt, e_gnt);
        chk("mem_re", oMemRe, e_re);
        chk("mem_addr", oMemAddr, e_addr);
        chk("busy", oBusy, m_owner >= 0);
        chk("rvd", oRvd, m_rvd);
        chk("rd", oRd, m_rd);
        if (oRvd != '0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_data actual=0x%0h required=<no word pending> at %0t", oRd, $time);
            end else begin
                chk("sb_data", oRd, exp_q.pop_front());
            end
        end
        for (int k = 0; k < N; k++) begin
            if (oRvd[k]) rvd_cnt[k]++;
            if (oGnt[k] && !prev_gnt[k]) gnt_log.push_back(k);
        end
        prev_gnt = oGnt;
    endtask

    task automatic tick();
        mem_drive();
        model_step();
        @(negedge iClk);
        check_outputs();
    endtask

    task automatic do_reset();
        iRst = 1'b0; iReq = '0; iFe = 1'b0;
        model_reset();
        flush_mem();
        tick();
        tick();
        iRst = 1'b1;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (gnt_log.size() < n && t < 1000) begin tick(); t++; end
        total++;
        if (t >= 1000) begin
            bad++;
            $display("FAIL wait_grants actual=%0d required=%0d", gnt_log.size(), n);
        end
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (!(gnt_log.size() >= n && !oBusy) && t < 1000) begin tick(); t++; end
        total++;
        if (t >= 1000) begin
            bad++;
            $display("FAIL wait_done actual=%0d required=%0d", gnt_log.size(), n);
        end
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        iReqAddr[k*AW +: AW] = a;
    endtask

    initial begin
        t4_exp = '{19'h7FFFC, 19'h7FFFD, 19'h7FFFE, 19'h7FFFF,
                   19'h00000, 19'h00001, 19'h00002, 19'h00003};
        @(negedge iClk);
        do_reset();
        chk("reset_gnt", oGnt, 0);
        chk("reset_re", oMemRe, 0);
        chk("reset_busy", oBusy, 0);

        // Single requester, fixed 3-clock return.
        clear_logs();
        rdy_mode = 0; dly_fixed = 3;
        set_addr(0, 19'h100);
        iReq = 4'b0001;
        tick();
        chk("t1_gnt_latency", oGnt, 4'b0001);
        iReq = '0;
        wait_done(1);
        chk("t1_grant_id", gnt_log[0], 0);
        chk("t1_cmd_count", addr_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_addr", addr_log[i], 19'h100 + 19'(i));
        chk("t1_rvd0", rvd_cnt[0], 8);
        chk("t1_rvd_other", rvd_cnt[1] + rvd_cnt[2] + rvd_cnt[3], 0);
        chk("t1_model_ptr", m_ptr, 1);

        // All four requesting: rotation 0,1,2,3.
        do_reset();
        clear_logs();
        rdy_mode = 2; dly_fixed = 0;
        for (int k = 0; k < N; k++) set_addr(k, AW'(32'h1000 * (k + 1) + 32'h40));
        iReq = 4'b1111;
        wait_grants(4);
        iReq = '0;
        wait_done(4);
        for (int k = 0; k < N; k++) begin
            chk("t2_order", gnt_log[k], k);
            chk("t2_words", rvd_cnt[k], 8);
        end

        // Ready toggling every clock.
        clear_logs();
        rdy_mode = 1;
        set_addr(1, 19'h2000);
        iReq = 4'b0010;
        tick();
        iReq = '0;
        wait_done(1);
        chk("t3_cmd_count", addr_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t3_addr", addr_log[i], 19'h2000 + 19'(i));

        // Address wrap at the top of the 19-bit space.
        clear_logs();
        rdy_mode = 0;
        set_addr(2, 19'h7FFFC);
        iReq = 4'b0100;
        tick();
        iReq = '0;
        wait_done(1);
        chk("t4_cmd_count", addr_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t4_addr", addr_log[i], t4_exp[i]);

        // Frame end during requester 2's burst sends the next grant to 0.
        do_reset();
        clear_logs();
        rdy_mode = 2;
        iReq = 4'b1111;
        wait_grants(3);
        tick();
        iFe = 1'b1;
        tick();
        iFe = 1'b0;
        wait_grants(4);
        chk("t5_third", gnt_log[2], 2);
        chk("t5_after_fe", gnt_log[3], 0);
        iReq = '0;
        wait_done(4);

        // Asynchronous reset in the ISSUE phase of the second burst.
        do_reset();
        clear_logs();
        iReq = 4'b1111;
        wait_grants(2);
        begin
            int t = 0;
            while (!oMemRe && t < 100) begin tick(); t++; end
        end
        #2 iRst = 1'b0;
        #1;
        chk("t6_async_gnt", oGnt, 0);
        chk("t6_async_re", oMemRe, 0);
        chk("t6_async_addr", oMemAddr, 0);
        chk("t6_async_rvd", oRvd, 0);
        chk("t6_async_rd", oRd, 0);
        chk("t6_async_busy", oBusy, 0);
        model_reset();
        flush_mem();
        iReq = '0;
        tick();
        tick();
        iRst = 1'b1;
        clear_logs();
        stale_n = 3;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_stale_rvd", rvd_cnt[0] + rvd_cnt[1] + rvd_cnt[2] + rvd_cnt[3], 0);
        set_addr(2, 19'h3300);
        iReq = 4'b0100;
        tick();
        chk("t6_regrant", oGnt, 4'b0100);
        iReq = '0;
        wait_done(1);
        chk("t6_words", rvd_cnt[2], 8);

        // Randomized traffic with frame-end pulses.
        rdy_mode = 2; dly_fixed = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (iReq[k] && oGnt[k]) begin
                    if ($urandom_range(0, 1) == 0) iReq[k] = 1'b0;
                end else if (!iReq[k] && $urandom_range(0, 5) == 0) begin
                    set_addr(k, AW'($urandom));
                    iReq[k] = 1'b1;
                end
            end
            iFe = ($urandom_range(0, 39) == 0);
            tick();
        end
        iFe = 1'b0;
        iReq = '0;
        begin
            int t = 0;
            while (oBusy && t < 500) begin tick(); t++; end
        end
        for (int i = 0; i < 3; i++) tick();
        chk("final_busy", oBusy, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
